// File: rtl/sdram_page_scheduler.sv
// Chooses the next full-page SDRAM transfer and its page, keeping the SDRAM as a circular page
// buffer. Define SDRAM_SCHED_STATS_EN to add the page counters and the sticky overflow_err flag.
module sdram_page_scheduler #(
    parameter int unsigned PAGE_WORDS  = 512,
    parameter int unsigned FIFO_CNT_W  = 10,
    parameter int unsigned PAGE_ADDR_W = 15
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en_write,
    input  logic                   en_read,
    input  logic [FIFO_CNT_W-1:0]  wr_fifo_count,
    input  logic [FIFO_CNT_W-1:0]  rd_fifo_free,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic                   cmd_write,
    output logic [PAGE_ADDR_W-1:0] cmd_page,
    input  logic                   cmd_done,
    output logic [PAGE_ADDR_W:0]   pages_stored,
    output logic                   buf_full,
    output logic                   buf_empty,
    output logic                   busy
`ifdef SDRAM_SCHED_STATS_EN
    ,
    output logic [31:0]            stat_wr_pages,
    output logic [31:0]            stat_rd_pages,
    output logic                   overflow_err
`endif
);

    localparam logic [FIFO_CNT_W:0]  THRESH = (FIFO_CNT_W + 1)'(PAGE_WORDS);
    localparam logic [PAGE_ADDR_W:0] DEPTH  = {1'b1, {PAGE_ADDR_W{1'b0}}};

    typedef enum logic [1:0] {StIdle, StIssue, StWaitDone} state_e;

    state_e                 state_q;
    logic                   en_write_q, en_read_q;
    logic [FIFO_CNT_W-1:0]  wr_cnt_q, rd_free_q;
    logic [PAGE_ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic                   last_wr_q;

    logic wr_want, wr_elig, rd_elig, pick_write;

    always_comb begin
        wr_want    = en_write_q && ({1'b0, wr_cnt_q} >= THRESH);
        wr_elig    = wr_want && !buf_full;
        rd_elig    = en_read_q && ({1'b0, rd_free_q} >= THRESH) && !buf_empty;
        // Round-robin: a write wins unless a read is also eligible and a write was served last.
        pick_write = wr_elig && (!rd_elig || !last_wr_q);
    end

    assign buf_full  = (pages_stored == DEPTH);
    assign buf_empty = (pages_stored == '0);
    assign busy      = (state_q != StIdle);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            en_write_q    <= 1'b0;
            en_read_q     <= 1'b0;
            wr_cnt_q      <= '0;
            rd_free_q     <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            last_wr_q     <= 1'b0;
            cmd_valid     <= 1'b0;
            cmd_write     <= 1'b0;
            cmd_page      <= '0;
            pages_stored  <= '0;
`ifdef SDRAM_SCHED_STATS_EN
            stat_wr_pages <= '0;
            stat_rd_pages <= '0;
            overflow_err  <= 1'b0;
`endif
        end else begin
            en_write_q <= en_write;
            en_read_q  <= en_read;
            wr_cnt_q   <= wr_fifo_count;
            rd_free_q  <= rd_fifo_free;
`ifdef SDRAM_SCHED_STATS_EN
            if (wr_want && buf_full) overflow_err <= 1'b1;
`endif
            case (state_q)
                StIdle: begin
                    if (wr_elig || rd_elig) begin
                        state_q   <= StIssue;
                        cmd_valid <= 1'b1;
                        cmd_write <= pick_write;
                        cmd_page  <= pick_write ? wr_ptr_q : rd_ptr_q;
                    end
                end
                StIssue: begin
                    if (cmd_ready) begin
                        state_q   <= StWaitDone;
                        cmd_valid <= 1'b0;
                    end
                end
                StWaitDone: begin
                    if (cmd_done) begin
                        state_q   <= StIdle;
                        last_wr_q <= cmd_write;
                        if (cmd_write) begin
                            wr_ptr_q      <= wr_ptr_q + 1'b1;
                            pages_stored  <= pages_stored + 1'b1;
`ifdef SDRAM_SCHED_STATS_EN
                            stat_wr_pages <= stat_wr_pages + 32'd1;
`endif
                        end else begin
                            rd_ptr_q      <= rd_ptr_q + 1'b1;
                            pages_stored  <= pages_stored - 1'b1;
`ifdef SDRAM_SCHED_STATS_EN
                            stat_rd_pages <= stat_rd_pages + 32'd1;
`endif
                        end
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    cmd_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_page_scheduler.sv
// Directed bench for sdram_page_scheduler with a 4-page buffer; a queue-based buffer model is
// checked against the DUT every cycle.
module tb_sdram_page_scheduler;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en_write, en_read;
    logic [9:0] wr_fifo_count, rd_fifo_free;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_done;
    logic [1:0] cmd_page;
    logic [2:0] pages_stored;
    logic       buf_full, buf_empty, busy;
`ifdef SDRAM_SCHED_STATS_EN
    logic [31:0] stat_wr_pages, stat_rd_pages;
    logic        overflow_err;
`endif

    int checks   = 0;
    int failures = 0;

    sdram_page_scheduler #(
        .PAGE_WORDS (512),
        .FIFO_CNT_W (10),
        .PAGE_ADDR_W(2)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .en_write     (en_write),
        .en_read      (en_read),
        .wr_fifo_count(wr_fifo_count),
        .rd_fifo_free (rd_fifo_free),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_page     (cmd_page),
        .cmd_done     (cmd_done),
        .pages_stored (pages_stored),
        .buf_full     (buf_full),
        .buf_empty    (buf_empty),
        .busy         (busy)
`ifdef SDRAM_SCHED_STATS_EN
        ,
        .stat_wr_pages(stat_wr_pages),
        .stat_rd_pages(stat_rd_pages),
        .overflow_err (overflow_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Buffer model: stored pages in write order, next write page, and the outstanding command.
    int   m_q[$];
    int   m_wr_ptr = 0;
    bit   m_out    = 0;
    bit   m_out_wr = 0;
    bit   hold     = 0;
    logic hold_w;
    logic [1:0] hold_p;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_q.delete();
            m_wr_ptr = 0;
            m_out    = 0;
            hold     = 0;
            check("m_rst_valid", cmd_valid, 0);
            check("m_rst_busy", busy, 0);
            check("m_rst_pages", pages_stored, 0);
        end else begin
            check("m_pages", pages_stored, m_q.size());
            check("m_full", buf_full, m_q.size() == DEPTH);
            check("m_empty", buf_empty, m_q.size() == 0);
            check("m_busy", busy, m_out || cmd_valid);
            if (m_out) check("m_valid_in_wait", cmd_valid, 0);
            if (hold) begin
                check("m_hold_valid", cmd_valid, 1);
                check("m_hold_write", cmd_write, hold_w);
                check("m_hold_page", cmd_page, hold_p);
            end
            if (m_out && cmd_done) begin
                m_out = 0;
                if (m_out_wr) begin
                    m_q.push_back(m_wr_ptr);
                    m_wr_ptr = (m_wr_ptr + 1) % DEPTH;
                end else if (m_q.size() > 0) begin
                    void'(m_q.pop_front());
                end
            end else if (cmd_valid && cmd_ready) begin
                m_out    = 1;
                m_out_wr = cmd_write;
                if (cmd_write) begin
                    check("m_wr_not_full", m_q.size() < DEPTH, 1);
                    check("m_wr_page", cmd_page, m_wr_ptr);
                end else begin
                    check("m_rd_not_empty", m_q.size() > 0, 1);
                    if (m_q.size() > 0) check("m_rd_page", cmd_page, m_q[0]);
                end
            end
            hold   = cmd_valid && !cmd_ready;
            hold_w = cmd_write;
            hold_p = cmd_page;
        end
    end

    task automatic wait_valid();
        int n = 0;
        while (!cmd_valid && n < 200) begin
            tick(1);
            n++;
        end
        check("cmd_valid_timeout", cmd_valid, 1);
    endtask

    // Wait for a command, accept it, set the enables, then complete it 20 cycles after accept.
    task automatic do_cmd(input logic ew_after, input logic er_after,
                          output logic typ, output logic [1:0] pg);
        wait_valid();
        typ = cmd_write;
        pg  = cmd_page;
        cmd_ready = 1'b1;
        tick(1);
        cmd_ready = 1'b0;
        en_write  = ew_after;
        en_read   = er_after;
        tick(19);
        cmd_done = 1'b1;
        tick(1);
        cmd_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       t;
        logic [1:0] p;
        bit         seen;
        logic       exp_t[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [1:0] exp_p[4] = '{2'd0, 2'd3, 2'd1, 2'd0};
        logic [2:0] exp_n[4] = '{3'd2, 3'd3, 3'd2, 3'd3};

        reset_n = 1'b0;
        en_write = 0; en_read = 0; wr_fifo_count = '0; rd_fifo_free = '0;
        cmd_ready = 0; cmd_done = 0;
        tick(3);
        check("rst_cmd_valid", cmd_valid, 0);
        check("rst_cmd_write", cmd_write, 0);
        check("rst_cmd_page", cmd_page, 0);
        check("rst_pages", pages_stored, 0);
        check("rst_empty", buf_empty, 1);
        check("rst_full", buf_full, 0);
        check("rst_busy", busy, 0);
        reset_n = 1'b1;
        tick(2);

        // Threshold: one word short never triggers a write.
        en_write = 1; wr_fifo_count = 10'd511;
        seen = 0;
        repeat (100) begin
            tick(1);
            if (cmd_valid) seen = 1;
        end
        check("thresh_511_idle", seen, 0);
        wr_fifo_count = 10'd512;
        tick(2);
        check("thresh_512_valid", cmd_valid, 1);
        check("first_write", cmd_write, 1);
        check("first_page", cmd_page, 0);

        do_cmd(1, 0, t, p);
        check("single_wr_pages", pages_stored, 1);
        check("single_wr_empty", buf_empty, 0);
        do_cmd(1, 0, t, p);
        check("wr2_page", p, 1);
        do_cmd(0, 0, t, p);
        check("wr3_page", p, 2);
        check("three_stored", pages_stored, 3);

        // Round-robin with both sides eligible; last served was a write.
        en_write = 1; en_read = 1; wr_fifo_count = 10'd600; rd_fifo_free = 10'd600;
        for (int i = 0; i < 4; i++) begin
            do_cmd(1, (i == 3) ? 1'b0 : 1'b1, t, p);
            check("rr_type", t, exp_t[i]);
            check("rr_page", p, exp_p[i]);
            check("rr_pages", pages_stored, exp_n[i]);
        end

        do_cmd(1, 0, t, p);
        check("fill_page", p, 1);
        check("full_flag", buf_full, 1);
        check("full_pages", pages_stored, 4);
        cmd_ready = 1;  // ready with nothing presented must be ignored
        seen = 0;
        repeat (30) begin
            tick(1);
            if (cmd_valid || busy) seen = 1;
        end
        cmd_ready = 0;
        check("no_5th_write", seen, 0);
`ifdef SDRAM_SCHED_STATS_EN
        check("overflow_err_set", overflow_err, 1);
`endif

        en_write = 0; en_read = 1;
        do_cmd(0, 0, t, p);
        check("read_after_full_type", t, 0);
        check("read_after_full_page", p, 2);
        check("read_after_full_pages", pages_stored, 3);

        // Backpressure: command must hold while en_write toggles; a stray done is ignored.
        en_write = 1;
        wait_valid();
        check("bp_write", cmd_write, 1);
        check("bp_page", cmd_page, 2);
        for (int i = 0; i < 10; i++) begin
            en_write = ~en_write;
            cmd_done = (i == 4);
            tick(1);
        end
        cmd_done = 0;
        en_write = 0;
        check("bp_still_valid", cmd_valid, 1);
        check("bp_still_page", cmd_page, 2);
        check("bp_stray_done_pages", pages_stored, 3);
        cmd_ready = 1;
        tick(1);
        cmd_ready = 0;
        tick(5);
        check("bp_accepted_valid", cmd_valid, 0);
        check("bp_accepted_busy", busy, 1);
        cmd_done = 1;
        tick(1);
        cmd_done = 0;
        check("bp_done_pages", pages_stored, 4);
`ifdef SDRAM_SCHED_STATS_EN
        check("stat_wr_before_rst", stat_wr_pages, 7);
        check("stat_rd_before_rst", stat_rd_pages, 3);
`endif

        // Reset while a read is in WAIT_DONE.
        en_read = 1;
        wait_valid();
        check("rst_mid_read_page", cmd_page, 3);
        cmd_ready = 1;
        tick(1);
        cmd_ready = 0;
        en_read = 0;
        tick(5);
        check("rst_mid_busy_before", busy, 1);
        reset_n = 0;
        #1;
        check("rst_mid_valid", cmd_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pages", pages_stored, 0);
        check("rst_mid_empty", buf_empty, 1);
        check("rst_mid_full", buf_full, 0);
        check("rst_mid_page", cmd_page, 0);
`ifdef SDRAM_SCHED_STATS_EN
        check("rst_mid_stat_wr", stat_wr_pages, 0);
        check("rst_mid_stat_rd", stat_rd_pages, 0);
        check("rst_mid_overflow", overflow_err, 0);
`endif
        tick(2);
        reset_n = 1;
        tick(2);
        cmd_done = 1;
        tick(1);
        cmd_done = 0;
        tick(2);
        check("late_done_pages", pages_stored, 0);
        check("late_done_busy", busy, 0);
        check("late_done_valid", cmd_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
